bram_rr_arbiter: RTL and testbench

- Shares port A of the single-clock true dual-port BRAM between NUM_REQ requesters, e.g. several simple BRAM controllers or DMA engines.
- Round-robin arbitration, one access per cycle. Optional burst lock lets one requester own the port for consecutive accesses.
- Registers the winning command onto the BRAM port and routes read data back to the originating requester with a one-hot valid.

---
 rtl/bram_rr_arbiter_pkg.sv | 10 +
 rtl/bram_rr_arbiter_if.sv | 13 +
 rtl/bram_rr_arbiter_picker.sv | 13 +
 rtl/bram_rr_arbiter.sv | 81 ++++++++
 tb/tb_bram_rr_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bram_rr_arbiter_pkg.sv
// bram_arb_pkg: FSM encoding, read latency and clog2 helper shared by the BRAM port-A arbiter
package bram_arb_pkg;
   typedef enum logic {S_ARB, S_LOCK} state_t;
   localparam int RD_LAT = 2;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/bram_rr_arbiter_if.sv
// bram_rr_arbiter_if: requester-side bus and BRAM port-A signals of the arbiter
interface bram_rr_arbiter_if #(parameter int NUM_REQ = 4, parameter int DWIDTH = 16, parameter int AWIDTH = 7);
   logic [NUM_REQ-1:0] i_req, i_lock, i_we, o_gnt, o_rvalid;
   logic [NUM_REQ*AWIDTH-1:0] i_addr;
   logic [NUM_REQ*DWIDTH-1:0] i_wdata;
   logic [DWIDTH-1:0] o_rdata, d0, q0;
   logic [AWIDTH-1:0] addr0;
   logic o_idle, ce0, we0;
   modport slave (input i_req, i_lock, i_we, i_addr, i_wdata, q0,
                  output o_gnt, o_rvalid, o_rdata, o_idle, addr0, ce0, we0, d0);
   modport master (output i_req, i_lock, i_we, i_addr, i_wdata, q0,
                   input o_gnt, o_rvalid, o_rdata, o_idle, addr0, ce0, we0, d0);
endinterface

// File: rtl/bram_rr_arbiter_picker.sv
// rr_priority_picker: one-hot round-robin winner via rotate, find-first, rotate-back
module rr_priority_picker #(parameter int NUM_REQ = 4, parameter int PW = 2) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt
);
   logic [NUM_REQ-1:0] rot, ff;
   always_comb begin
      rot = NUM_REQ'({req, req} >> ptr);
      ff = rot & (~rot + 1'b1);
      gnt = NUM_REQ'(({ff, ff} << ptr) >> NUM_REQ);
   end
endmodule

// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter: round-robin arbiter with burst lock sharing BRAM port A among NUM_REQ requesters
// Define BRAM_ARB_STAT_EN to add per-requester saturating accept counters.
module bram_rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 7,
   parameter int MEM_SIZE = 128,
   localparam int PW = clog2(NUM_REQ)
) (
   input logic clk,
   input logic reset,
   bram_rr_arbiter_if.slave bus
`ifdef BRAM_ARB_STAT_EN
   ,
   input  logic          i_clr_stat,
   input  logic [PW-1:0] i_sel_stat,
   output logic [15:0]   o_gnt_cnt
`endif
);
   if (MEM_SIZE < 1 || MEM_SIZE > (1 << AWIDTH)) begin : g_bad_size
      $error("MEM_SIZE does not fit the address width");
   end
   state_t state;
   logic [PW-1:0] ptr, owner, k;
   logic [NUM_REQ-1:0] rr_gnt, gnt, acc;
   logic [RD_LAT-1:0][NUM_REQ-1:0] tag;
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
      return (v == PW'(NUM_REQ - 1)) ? '0 : v + 1'b1;
   endfunction
   rr_priority_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (.req(bus.i_req), .ptr(ptr), .gnt(rr_gnt));
   // Grant is masked during reset so nothing is accepted while the pipeline is cleared
   always_comb begin
      gnt = reset ? '0 : (state == S_LOCK) ? bus.i_req & (NUM_REQ'(1) << owner) : rr_gnt;
      acc = bus.i_req & gnt;
      k = '0;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) k = PW'(i);
   end
   assign bus.o_gnt = gnt;
   assign bus.o_rvalid = tag[RD_LAT-1];
   assign bus.o_rdata = bus.q0;
   assign bus.o_idle = (state == S_ARB) & ~bus.ce0 & ~|tag;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_ARB;
         ptr <= '0;
         owner <= '0;
         tag <= '0;
         bus.addr0 <= '0;
         bus.ce0 <= 1'b0;
         bus.we0 <= 1'b0;
         bus.d0 <= '0;
      end else begin
         bus.ce0 <= |acc;
         bus.we0 <= |acc & bus.i_we[k];
         if (|acc) begin
            bus.addr0 <= bus.i_addr[k*AWIDTH +: AWIDTH];
            bus.d0 <= bus.i_wdata[k*DWIDTH +: DWIDTH];
         end
         tag <= {tag[RD_LAT-2:0], acc & ~bus.i_we};
         if (state == S_ARB) begin
            if (|acc && bus.i_lock[k]) begin
               state <= S_LOCK;
               owner <= k;
            end else if (|acc) ptr <= inc(k);
         end else if (!bus.i_req[owner] || !bus.i_lock[owner]) begin
            state <= S_ARB;
            ptr <= inc(owner);
         end
      end
   end
`ifdef BRAM_ARB_STAT_EN
   logic [15:0] cnt [NUM_REQ];
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++)
         cnt[i] <= (reset || i_clr_stat) ? '0 : (acc[i] && cnt[i] != 16'hFFFF) ? cnt[i] + 1'b1 : cnt[i];
      o_gnt_cnt <= reset ? '0 : cnt[i_sel_stat];
   end
`endif
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb_bram_rr_arbiter: directed scoreboard bench for bram_rr_arbiter with a behavioural BRAM on port A
module tb_bram_rr_arbiter;
   localparam int N = 4, DW = 16, AW = 7;
   logic clk = 1'b0, reset = 1'b1;
   int total = 0, bad = 0;
   int rv_cnt [N] = '{default: 0};
   logic [19:0] sb [$];
   logic [19:0] mon_e;
   logic [DW-1:0] mem [128];
   always #5 clk = ~clk;
   bram_rr_arbiter_if #(.NUM_REQ(N), .DWIDTH(DW), .AWIDTH(AW)) bus ();
`ifdef BRAM_ARB_STAT_EN
   logic clr_stat = 1'b0;
   logic [1:0] sel_stat = 2'd0;
   logic [15:0] gnt_cnt;
`endif
   bram_rr_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(128)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef BRAM_ARB_STAT_EN
      ,
      .i_clr_stat(clr_stat),
      .i_sel_stat(sel_stat),
      .o_gnt_cnt(gnt_cnt)
`endif
   );
   initial for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
   always @(posedge clk) begin
      if (bus.ce0) begin
         if (bus.we0) mem[bus.addr0] <= bus.d0;
         else bus.q0 <= mem[bus.addr0];
      end
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic drv(input int k, input logic r, input logic w, input logic l, input int a, input logic [15:0] d);
      bus.i_req[k] = r;
      bus.i_we[k] = w;
      bus.i_lock[k] = l;
      bus.i_addr[k*AW +: AW] = AW'(a);
      bus.i_wdata[k*DW +: DW] = d;
   endtask
   task automatic clr_all;
      bus.i_req = '0;
      bus.i_lock = '0;
      bus.i_we = '0;
   endtask
   task automatic exp_rd(input int k, input int a);
      logic [15:0] v;
      v = (a == 3) ? 16'h00A5 : 16'h1000 + 16'(a);
      sb.push_back({4'(1 << k), v});
   endtask
   // Monitor: every read-data beat is matched against the oldest expected read
   always @(negedge clk) begin
      if (bus.o_rvalid != '0) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rvalid_unexpected act=%b exp=none t=%0t", bus.o_rvalid, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("rvalid", 32'(bus.o_rvalid), 32'(mon_e[19:16]));
            chk("rdata", 32'(bus.o_rdata), 32'(mon_e[15:0]));
         end
         for (int i = 0; i < N; i++) if (bus.o_rvalid[i]) rv_cnt[i]++;
      end
   end
   initial begin
      bus.i_req = '0;
      bus.i_lock = '0;
      bus.i_we = '0;
      bus.i_addr = '0;
      bus.i_wdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_ce0", 32'(bus.ce0), 0);
      chk("rst_we0", 32'(bus.we0), 0);
      chk("rst_addr0", 32'(bus.addr0), 0);
      chk("rst_d0", 32'(bus.d0), 0);
      chk("rst_rvalid", 32'(bus.o_rvalid), 0);
      chk("rst_gnt", 32'(bus.o_gnt), 0);
      chk("rst_idle", 32'(bus.o_idle), 1);
      // single write then read by requester 0
      drv(0, 1, 1, 0, 3, 16'h00A5);
      #1 chk("wr_gnt", 32'(bus.o_gnt), 4'b0001);
      cyc;
      chk("wr_ce0", 32'(bus.ce0), 1);
      chk("wr_we0", 32'(bus.we0), 1);
      chk("wr_addr0", 32'(bus.addr0), 3);
      chk("wr_d0", 32'(bus.d0), 16'h00A5);
      chk("wr_idle", 32'(bus.o_idle), 0);
      drv(0, 1, 0, 0, 3, 16'h0000);
      #1 chk("rd_gnt", 32'(bus.o_gnt), 4'b0001);
      exp_rd(0, 3);
      cyc;
      chk("rd_ce0", 32'(bus.ce0), 1);
      chk("rd_we0", 32'(bus.we0), 0);
      clr_all;
      cyc;
      chk("noacc_ce0", 32'(bus.ce0), 0);
      chk("noacc_addr_hold", 32'(bus.addr0), 3);
      cyc;
      chk("idle_back", 32'(bus.o_idle), 1);
      // write by requester 3 moves the pointer to 0
      drv(3, 1, 1, 0, 50, 16'h0BEE);
      #1 chk("ptr_prep_gnt", 32'(bus.o_gnt), 4'b1000);
      cyc;
      clr_all;
      // round-robin fairness
      for (int k = 0; k < N; k++) drv(k, 1, 0, 0, 40 + k, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         #1 chk("rr_gnt", 32'(bus.o_gnt), 32'(1 << (i % 4)));
         exp_rd(i % 4, 40 + i % 4);
         cyc;
      end
      clr_all;
      repeat (2) cyc;
      chk("rr_cnt0", 32'(rv_cnt[0]), 3);
      chk("rr_cnt1", 32'(rv_cnt[1]), 2);
      chk("rr_cnt2", 32'(rv_cnt[2]), 2);
      chk("rr_cnt3", 32'(rv_cnt[3]), 2);
      // burst lock by requester 1 against 0 and 2
      drv(0, 1, 0, 0, 60, 16'h0000);
      drv(2, 1, 0, 0, 62, 16'h0000);
      drv(1, 1, 0, 1, 10, 16'h0000);
      #1 chk("pre_lock_gnt", 32'(bus.o_gnt), 4'b0001);
      exp_rd(0, 60);
      cyc;
      for (int i = 0; i < 5; i++) begin
         drv(1, 1, 0, i < 4, 10 + i, 16'h0000);
         #1 chk("lock_gnt", 32'(bus.o_gnt), 4'b0010);
         exp_rd(1, 10 + i);
         cyc;
      end
      #1 chk("post_lock_gnt", 32'(bus.o_gnt), 4'b0100);
      exp_rd(2, 62);
      cyc;
      clr_all;
      repeat (2) cyc;
      // lock released by a dropped request
      drv(3, 1, 0, 1, 70, 16'h0000);
      #1 chk("lock3_gnt", 32'(bus.o_gnt), 4'b1000);
      exp_rd(3, 70);
      cyc;
      drv(3, 0, 0, 0, 70, 16'h0000);
      drv(0, 1, 0, 0, 71, 16'h0000);
      #1 chk("drop_gnt", 32'(bus.o_gnt), 4'b0000);
      cyc;
      #1 chk("drop_next_gnt", 32'(bus.o_gnt), 4'b0001);
      exp_rd(0, 71);
      cyc;
      clr_all;
      repeat (2) cyc;
      // reset mid-operation: second read and the lock are discarded
      drv(1, 1, 0, 0, 5, 16'h0000);
      #1 chk("mid_gnt1", 32'(bus.o_gnt), 4'b0010);
      exp_rd(1, 5);
      cyc;
      drv(1, 0, 0, 0, 5, 16'h0000);
      drv(2, 1, 0, 1, 6, 16'h0000);
      #1 chk("mid_gnt2", 32'(bus.o_gnt), 4'b0100);
      cyc;
      reset = 1'b1;
      for (int k = 0; k < N; k++) drv(k, 1, 0, 0, 20 + k, 16'h0000);
      #1 chk("rst_gnt_gated", 32'(bus.o_gnt), 0);
      cyc;
      chk("midrst_rvalid", 32'(bus.o_rvalid), 0);
      chk("midrst_ce0", 32'(bus.ce0), 0);
      chk("midrst_gnt", 32'(bus.o_gnt), 0);
      reset = 1'b0;
      chk("midrst_idle", 32'(bus.o_idle), 1);
      #1 chk("midrst_ptr_gnt", 32'(bus.o_gnt), 4'b0001);
      clr_all;
      cyc;
      chk("post_rst_rvalid", 32'(bus.o_rvalid), 0);
      chk("post_rst_idle", 32'(bus.o_idle), 1);
`ifdef BRAM_ARB_STAT_EN
      for (int i = 0; i < 3; i++) begin
         drv(2, 1, 1, 0, 90 + i, 16'(i));
         #1 chk("stat_gnt", 32'(bus.o_gnt), 4'b0100);
         cyc;
      end
      clr_all;
      sel_stat = 2'd2;
      cyc;
      chk("stat_cnt", 32'(gnt_cnt), 3);
      clr_stat = 1'b1;
      cyc;
      clr_stat = 1'b0;
      cyc;
      chk("stat_clr", 32'(gnt_cnt), 0);
`endif
      repeat (3) cyc;
      chk("queue_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
